// File: rtl/cache_wb.sv
// cache_wb: direct-mapped, write-back, write-allocate cache with one word per line.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_wb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL,
        FILL_WAIT
    } state_t;

    state_t state;

    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;

    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              miss;

    logic [INDEX_W-1:0] in_idx;
    logic [TAG_W-1:0]   in_tag;
    logic [INDEX_W-1:0] r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic               in_hit;

    assign in_idx = cpu_addr[INDEX_W-1:0];
    assign in_tag = cpu_addr[ADDR_W-1:INDEX_W];
    assign r_idx  = req_addr[INDEX_W-1:0];
    assign r_tag  = req_addr[ADDR_W-1:INDEX_W];
    assign in_hit = valid[in_idx] && (tags[in_idx] == in_tag);

    // The hit lookup is done as the request is accepted so that the
    // completion outputs are registered and appear in the COMPARE cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            busy      <= 1'b0;
            mem_we    <= 1'b0;
            cpu_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            miss      <= 1'b0;
`ifdef CACHE_STATS_EN
            hit_cnt   <= '0;
            miss_cnt  <= '0;
`endif
        end else begin
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        miss      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= COMPARE;
                        if (in_hit) begin
                            cpu_ready <= 1'b1;
                            cpu_hit   <= 1'b1;
                            cpu_rdata <= data[in_idx];
`ifdef CACHE_STATS_EN
                            if (hit_cnt != 16'hFFFF)
                                hit_cnt <= hit_cnt + 16'd1;
`endif
                        end
                    end
                end
                COMPARE: begin
                    if (cpu_ready) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (req_we)
                            dirty[r_idx] <= 1'b1;
                    end else begin
                        miss <= 1'b1;
                        if (valid[r_idx] && dirty[r_idx]) begin
                            state     <= WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {tags[r_idx], r_idx};
                            mem_wdata <= data[r_idx];
                        end else begin
                            state    <= FILL;
                            mem_addr <= req_addr;
                        end
                    end
                end
                WRITEBACK: begin
                    state    <= FILL;
                    mem_addr <= req_addr;
                end
                FILL: begin
                    state <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    valid[r_idx] <= 1'b1;
                    dirty[r_idx] <= 1'b0;
                    state        <= COMPARE;
                    cpu_ready    <= 1'b1;
                    cpu_hit      <= ~miss;
                    cpu_rdata    <= mem_rdata;
`ifdef CACHE_STATS_EN
                    if (miss_cnt != 16'hFFFF)
                        miss_cnt <= miss_cnt + 16'd1;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays keep their contents across reset.
    always_ff @(posedge clock) begin
        if (state == FILL_WAIT) begin
            data[r_idx] <= mem_rdata;
            tags[r_idx] <= r_tag;
        end else if (state == COMPARE && cpu_ready && req_we) begin
            data[r_idx] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_cache_wb.sv
// tb_cache_wb: directed and random transactions against a line-level
// cache model plus a backing-memory model.
module tb_cache_wb;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic       cpu_ready;
    logic       cpu_hit;
    logic       busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    cache_wb dut (
        .clock     (clock),
        .resetn    (resetn),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_hit   (cpu_hit),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Registered synchronous backing RAM with a preload port.
    logic [7:0] ram [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [7:0] pre_data = '0;

    always @(posedge clock) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model: cache lines and backing memory contents.
    logic       m_valid [8];
    logic       m_dirty [8];
    logic [4:0] m_tag   [8];
    logic [7:0] m_data  [8];
    logic [7:0] mram    [256];
    int         exp_hits = 0;
    int         exp_misses = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic run_txn(input logic we,
                           input logic [7:0] a,
                           input logic [7:0] d);
        logic [2:0] idx;
        logic [4:0] tg;
        logic       e_hit;
        logic       e_wb;
        int         e_lat;
        logic [7:0] e_wa;
        logic [7:0] e_wd;
        logic [7:0] e_rd;
        int         lat;
        int         nwb;
        logic [7:0] g_wa;
        logic [7:0] g_wd;
        logic [7:0] g_rd;
        logic       g_hit;
        idx   = a[2:0];
        tg    = a[7:3];
        e_hit = m_valid[idx] && (m_tag[idx] == tg);
        e_wb  = !e_hit && m_valid[idx] && m_dirty[idx];
        e_lat = e_hit ? 1 : (e_wb ? 5 : 4);
        e_wa  = {m_tag[idx], idx};
        e_wd  = m_data[idx];
        if (e_wb)
            mram[e_wa] = e_wd;
        if (!e_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = mram[a];
            m_dirty[idx] = 1'b0;
        end
        e_rd = m_data[idx];
        if (we) begin
            m_data[idx]  = d;
            m_dirty[idx] = 1'b1;
        end
        if (e_hit)
            exp_hits++;
        else
            exp_misses++;

        @(negedge clock);
        check("idle_busy", busy, 0);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        @(posedge clock);
        #1 cpu_req = 1'b0;
        lat   = 0;
        nwb   = 0;
        g_wa  = '0;
        g_wd  = '0;
        g_rd  = '0;
        g_hit = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clock);
            if (mem_we) begin
                nwb++;
                g_wa = mem_addr;
                g_wd = mem_wdata;
            end
            if (cpu_ready) begin
                lat   = c;
                g_rd  = cpu_rdata;
                g_hit = cpu_hit;
            end
        end
        check("latency", lat, e_lat);
        check("hit", g_hit, e_hit);
        if (!we)
            check("rdata", g_rd, e_rd);
        check("wb_count", nwb, e_wb);
        if (e_wb) begin
            check("wb_addr", g_wa, e_wa);
            check("wb_data", g_wd, e_wd);
        end
`ifdef CACHE_STATS_EN
        check("hit_cnt", hit_cnt, exp_hits);
        check("miss_cnt", miss_cnt, exp_misses);
`endif
    endtask

    initial begin
        int nr;
        int nwb;
        logic seen;

        model_reset();
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            pre_we   = 1'b1;
            pre_addr = 8'(i);
            pre_data = (i == 8'h12) ? 8'h5A : 8'($urandom);
            mram[i]  = pre_data;
        end
        @(negedge clock);
        pre_we = 1'b0;

        check("rst_ready", cpu_ready, 0);
        check("rst_hit", cpu_hit, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
`ifdef CACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
`endif
        @(negedge clock);
        resetn = 1'b1;

        // Abort a clean miss while it sits in FILL_WAIT.
        @(negedge clock);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h12;
        @(posedge clock);
        #1 cpu_req = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            if (cpu_ready)
                seen = 1'b1;
        end
        check("abort_early_ready", seen, 0);
        resetn = 1'b0;
        #1;
        check("abort_ready", cpu_ready, 0);
        check("abort_mem_we", mem_we, 0);
        check("abort_busy", busy, 0);
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (cpu_ready || mem_we)
                seen = 1'b1;
        end
        resetn = 1'b1;
        check("abort_quiet", seen, 0);
        model_reset();

        run_txn(1'b0, 8'h12, 8'h00);
        run_txn(1'b0, 8'h12, 8'h00);
        run_txn(1'b1, 8'h12, 8'h33);
        run_txn(1'b0, 8'h1A, 8'h00);
        run_txn(1'b1, 8'h40, 8'h77);
        run_txn(1'b0, 8'h40, 8'h00);

        // Held request: one miss, then one hit, no queueing.
        @(negedge clock);
        check("hold_busy", busy, 0);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h55;
        m_valid[5] = 1'b1;
        m_tag[5]   = 5'h0A;
        m_data[5]  = mram[8'h55];
        m_dirty[5] = 1'b0;
        exp_hits++;
        exp_misses++;
        nr  = 0;
        nwb = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (mem_we)
                nwb++;
            if (cpu_ready) begin
                nr++;
                check("hold_rdata", cpu_rdata, mram[8'h55]);
                if (nr == 1) begin
                    check("hold_lat1", c, 4);
                    check("hold_hit1", cpu_hit, 0);
                end else if (nr == 2) begin
                    check("hold_lat2", c, 6);
                    check("hold_hit2", cpu_hit, 1);
                    cpu_req = 1'b0;
                end
            end
        end
        cpu_req = 1'b0;
        check("hold_count", nr, 2);
        check("hold_wb", nwb, 0);
`ifdef CACHE_STATS_EN
        check("hold_hit_cnt", hit_cnt, exp_hits);
        check("hold_miss_cnt", miss_cnt, exp_misses);
`endif

        for (int i = 0; i < 200; i++)
            run_txn(1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 63)),
                    8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
